// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, function codes, status codes,
// register sentinel and condition-code bit positions.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_XOR = 2'd3
   } alu_fn_e;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   localparam logic [3:0] RNONE = 4'hF;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   // Branch / cmov condition from the registered {ZF,SF,OF}; undefined ifuns never fire.
   function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
      logic zf, sf, of_b, res;
      zf   = cc[CC_ZF];
      sf   = cc[CC_SF];
      of_b = cc[CC_OF];
      case (ifun)
         C_YES:   res = 1'b1;
         C_LE:    res = (sf ^ of_b) | zf;
         C_L:     res = sf ^ of_b;
         C_E:     res = zf;
         C_NE:    res = ~zf;
         C_GE:    res = ~(sf ^ of_b);
         C_G:     res = ~(sf ^ of_b) & ~zf;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/y86_execute_stage_if.sv
// Decode-to-execute and execute-to-memory handshake bundle for the E stage.
interface y86_execute_stage_if #(parameter int DATA_W = 64);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_stat;
   logic [3:0]        in_icode;
   logic [3:0]        in_ifun;
   logic [DATA_W-1:0] in_valA;
   logic [DATA_W-1:0] in_valB;
   logic [DATA_W-1:0] in_valC;
   logic [3:0]        in_dstE;
   logic [3:0]        in_dstM;
   logic              flush;
   logic              cc_block;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_stat;
   logic [3:0]        out_icode;
   logic              out_cnd;
   logic [DATA_W-1:0] out_valE;
   logic [DATA_W-1:0] out_valA;
   logic [3:0]        out_dstE;
   logic [3:0]        out_dstM;
   logic [2:0]        cc;

   modport slave (
      input  in_valid, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
             in_dstE, in_dstM, flush, cc_block, out_ready,
      output in_ready, out_valid, out_stat, out_icode, out_cnd, out_valE,
             out_valA, out_dstE, out_dstM, cc
   );

   modport master (
      output in_valid, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
             in_dstE, in_dstM, flush, cc_block, out_ready,
      input  in_ready, out_valid, out_stat, out_icode, out_cnd, out_valE,
             out_valA, out_dstE, out_dstM, cc
   );
endinterface

// File: rtl/alu64.sv
// Combinational Y86 ALU: result = b op a, with signed overflow for add/sub.
module alu64
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  alu_fn_e      fn,
   output logic [W-1:0] result,
   output logic         of
);

   always_comb begin
      result = '0;
      of     = 1'b0;
      case (fn)
         ALU_ADD: begin
            result = b + a;
            of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
         end
         ALU_SUB: begin
            result = b - a;
            of     = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
         end
         ALU_AND: result = b & a;
         default: result = b ^ a;
      endcase
   end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, Cnd, and a
// single registered output slot with valid/ready on both sides.
module y86_execute_stage
   import y86_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input logic                 clk,
   input logic                 rst_n,
   y86_execute_stage_if.slave  bus
);

   logic              accept, cc_we, cnd;
   logic [DATA_W-1:0] alu_a, alu_b, alu_res;
   alu_fn_e           alu_fn;
   logic              alu_of;

   logic [2:0]        cc_q, cc_d;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        stat_q, stat_d;
   logic [3:0]        icode_q, icode_d;
   logic              cnd_q, cnd_d;
   logic [DATA_W-1:0] valE_q, valE_d, valA_q, valA_d;
   logic [3:0]        dstE_q, dstE_d, dstM_q, dstM_d;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_fn = ALU_ADD;
      case (bus.in_icode)
         I_OPQ: begin
            alu_a  = bus.in_valA;
            alu_b  = bus.in_valB;
            alu_fn = alu_fn_e'(bus.in_ifun[1:0]);
         end
         I_RRMOVQ: alu_a = bus.in_valA;
         I_IRMOVQ: alu_a = bus.in_valC;
         I_RMMOVQ, I_MRMOVQ: begin
            alu_a = bus.in_valC;
            alu_b = bus.in_valB;
         end
         I_CALL, I_PUSHQ: begin
            alu_a  = DATA_W'(8);
            alu_b  = bus.in_valB;
            alu_fn = ALU_SUB;
         end
         I_RET, I_POPQ: begin
            alu_a = DATA_W'(8);
            alu_b = bus.in_valB;
         end
         default: ;
      endcase
   end

   alu64 #(.W(DATA_W)) u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .fn     (alu_fn),
      .result (alu_res),
      .of     (alu_of)
   );

   // Cnd sees only the committed CC, never the OPq being accepted alongside it.
   assign cnd = (bus.in_icode == I_RRMOVQ || bus.in_icode == I_JXX)
              ? cond_eval(bus.in_ifun, cc_q) : 1'b1;

   assign cc_we = accept && (bus.in_icode == I_OPQ) && (bus.in_stat == STAT_AOK)
               && !bus.cc_block && !bus.flush;

   always_comb begin
      cc_d = cc_q;
      if (cc_we) begin
         cc_d[CC_ZF] = (alu_res == '0);
         cc_d[CC_SF] = alu_res[DATA_W-1];
         cc_d[CC_OF] = alu_of;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      stat_d      = stat_q;
      icode_d     = icode_q;
      cnd_d       = cnd_q;
      valE_d      = valE_q;
      valA_d      = valA_q;
      dstE_d      = dstE_q;
      dstM_d      = dstM_q;
      if (accept) begin
         out_valid_d = !bus.flush;
         if (bus.flush) begin
            // Squashed instruction becomes a nop bubble.
            stat_d  = STAT_AOK;
            icode_d = I_NOP;
            cnd_d   = 1'b0;
            valE_d  = '0;
            valA_d  = '0;
            dstE_d  = RNONE;
            dstM_d  = RNONE;
         end else begin
            stat_d  = bus.in_stat;
            icode_d = bus.in_icode;
            cnd_d   = cnd;
            valE_d  = alu_res;
            valA_d  = bus.in_valA;
            dstE_d  = (bus.in_icode == I_RRMOVQ && !cnd) ? RNONE : bus.in_dstE;
            dstM_d  = bus.in_dstM;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q        <= 3'b100;
         out_valid_q <= 1'b0;
         stat_q      <= STAT_AOK;
         icode_q     <= I_NOP;
         cnd_q       <= 1'b0;
         valE_q      <= '0;
         valA_q      <= '0;
         dstE_q      <= RNONE;
         dstM_q      <= RNONE;
      end else begin
         cc_q        <= cc_d;
         out_valid_q <= out_valid_d;
         stat_q      <= stat_d;
         icode_q     <= icode_d;
         cnd_q       <= cnd_d;
         valE_q      <= valE_d;
         valA_q      <= valA_d;
         dstE_q      <= dstE_d;
         dstM_q      <= dstM_d;
      end
   end

   assign bus.cc        = cc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_stat  = stat_q;
   assign bus.out_icode = icode_q;
   assign bus.out_cnd   = cnd_q;
   assign bus.out_valE  = valE_q;
   assign bus.out_valA  = valA_q;
   assign bus.out_dstE  = dstE_q;
   assign bus.out_dstM  = dstM_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed bench for the Y86-64 execute stage with a cycle-level reference model.
module tb_y86_execute_stage;

   logic clk;
   logic rst_n;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   y86_execute_stage_if #(.DATA_W(64)) bus ();

   y86_execute_stage #(.DATA_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic void model_alu(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c,
                                     output logic [63:0] r, output logic ov);
      logic [64:0] w;
      r  = 64'd0;
      ov = 1'b0;
      case (ic)
         4'h6: case (fn)
            4'h0: begin w = {b[63], b} + {a[63], a}; r = w[63:0]; ov = (w[64] != w[63]); end
            4'h1: begin w = {b[63], b} - {a[63], a}; r = w[63:0]; ov = (w[64] != w[63]); end
            4'h2: r = a & b;
            4'h3: r = a ^ b;
            default: r = 64'd0;
         endcase
         4'h2:        r = a;
         4'h3:        r = c;
         4'h4, 4'h5:  r = b + c;
         4'h8, 4'hA:  r = b - 64'd8;
         4'h9, 4'hB:  r = b + 64'd8;
         default:     r = 64'd0;
      endcase
   endfunction

   function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic zf, input logic sf, input logic of);
      if (ic != 4'h2 && ic != 4'h7) return 1'b1;
      case (fn)
         4'h0:    return 1'b1;
         4'h1:    return (sf != of) || zf;
         4'h2:    return sf != of;
         4'h3:    return zf;
         4'h4:    return !zf;
         4'h5:    return sf == of;
         4'h6:    return (sf == of) && !zf;
         default: return 1'b0;
      endcase
   endfunction

   logic        m_valid, m_cnd, m_zf, m_sf, m_of, m_acc, m_ov;
   logic [1:0]  m_stat;
   logic [3:0]  m_icode, m_dstE, m_dstM;
   logic [63:0] m_valE, m_valA, m_r;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
      end else begin
         m_acc = bus.in_valid && (!m_valid || bus.out_ready);
         if (m_acc) begin
            model_alu(bus.in_icode, bus.in_ifun, bus.in_valA, bus.in_valB, bus.in_valC, m_r, m_ov);
            $display("txn t=%0t stat=%0d icode=%0h ifun=%0h valE=0x%0h flush=%0b ccb=%0b",
                     $time, bus.in_stat, bus.in_icode, bus.in_ifun, m_r, bus.flush, bus.cc_block);
            if (!bus.flush) begin
               m_valid = 1'b1;
               m_stat  = bus.in_stat;
               m_icode = bus.in_icode;
               m_cnd   = model_cnd(bus.in_icode, bus.in_ifun, m_zf, m_sf, m_of);
               m_valE  = m_r;
               m_valA  = bus.in_valA;
               m_dstE  = (bus.in_icode == 4'h2 && !m_cnd) ? 4'hF : bus.in_dstE;
               m_dstM  = bus.in_dstM;
            end else begin
               m_valid = 1'b0;
            end
            if (bus.in_icode == 4'h6 && bus.in_stat == 2'd0 && !bus.cc_block && !bus.flush) begin
               m_zf = (m_r == 64'd0);
               m_sf = m_r[63];
               m_of = m_ov;
            end
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
      #1;
      check("m_out_valid", bus.out_valid, m_valid);
      check("m_in_ready", bus.in_ready, !m_valid || bus.out_ready);
      check("m_cc", bus.cc, {m_zf, m_sf, m_of});
      if (m_valid) begin
         check("m_stat", bus.out_stat, m_stat);
         check("m_icode", bus.out_icode, m_icode);
         check("m_cnd", bus.out_cnd, m_cnd);
         check("m_valE", bus.out_valE, m_valE);
         check("m_valA", bus.out_valA, m_valA);
         check("m_dstE", bus.out_dstE, m_dstE);
         check("m_dstM", bus.out_dstM, m_dstM);
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic fl, input logic cb);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_stat  = st;
      bus.in_icode = ic;
      bus.in_ifun  = fn;
      bus.in_valA  = a;
      bus.in_valB  = b;
      bus.in_valC  = c;
      bus.in_dstE  = de;
      bus.in_dstM  = dm;
      bus.flush    = fl;
      bus.cc_block = cb;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.cc_block = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  ic;
      logic [3:0]  fn;
      logic [63:0] a, b, c, ev;
      logic [2:0]  ecc;
   } vec_t;

   vec_t vecs[9];
   int   jf[8];
   logic je[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{4'h6, 4'h2, 64'hFF00, 64'hF0F0, 64'h0, 64'hF000, 3'b000};
      vecs[1] = '{4'h6, 4'h3, 64'hFF, 64'hFF, 64'h0, 64'h0, 3'b100};
      vecs[2] = '{4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
      vecs[3] = '{4'h3, 4'h0, 64'h0, 64'h0, 64'h55, 64'h55, 3'b001};
      vecs[4] = '{4'h4, 4'h0, 64'h0, 64'h100, 64'h8, 64'h108, 3'b001};
      vecs[5] = '{4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 64'hF8, 3'b001};
      vecs[6] = '{4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 64'h108, 3'b001};
      vecs[7] = '{4'h0, 4'h0, 64'h5, 64'h6, 64'h0, 64'h0, 3'b001};
      vecs[8] = '{4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 3'b101};
      jf = '{0, 1, 2, 3, 4, 5, 6, 9};
      je = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b1;
      bus.in_valid = 1'b0; bus.in_stat = 2'd0; bus.in_icode = 4'h1; bus.in_ifun = 4'h0;
      bus.in_valA = '0; bus.in_valB = '0; bus.in_valC = '0;
      bus.in_dstE = 4'hF; bus.in_dstM = 4'hF;
      bus.flush = 1'b0; bus.cc_block = 1'b0; bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_cc", bus.cc, 3'b100);
      check("rst_icode", bus.out_icode, 4'h1);
      check("rst_stat", bus.out_stat, 2'd0);
      check("rst_cnd", bus.out_cnd, 1'b0);
      check("rst_valE", bus.out_valE, 64'd0);
      check("rst_valA", bus.out_valA, 64'd0);
      check("rst_dstE", bus.out_dstE, 4'hF);
      check("rst_dstM", bus.out_dstM, 4'hF);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // sub 0x13 - 0xA
      issue(2'd0, 4'h6, 4'h1, 64'hA, 64'h13, 64'h0, 4'h2, 4'hF, 1'b0, 1'b0);
      check("sub_valE", bus.out_valE, 64'h9);
      check("sub_cc", bus.cc, 3'b000);
      // add overflow then jl
      issue(2'd0, 4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h2, 4'hF, 1'b0, 1'b0);
      check("addov_valE", bus.out_valE, 64'h8000_0000_0000_0000);
      check("addov_cc", bus.cc, 3'b011);
      issue(2'd0, 4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF, 1'b0, 1'b0);
      check("jl_cnd", bus.out_cnd, 1'b0);
      // cmovle taken / not taken
      issue(2'd0, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h1, 4'hF, 1'b0, 1'b0);
      check("eq_cc", bus.cc, 3'b100);
      issue(2'd0, 4'h2, 4'h1, 64'h1234, 64'h0, 64'h0, 4'h3, 4'hF, 1'b0, 1'b0);
      check("cmov_cnd", bus.out_cnd, 1'b1);
      check("cmov_valE", bus.out_valE, 64'h1234);
      check("cmov_dstE", bus.out_dstE, 4'h3);
      issue(2'd0, 4'h6, 4'h0, 64'h1, 64'h2, 64'h0, 4'h1, 4'hF, 1'b0, 1'b0);
      check("add3_cc", bus.cc, 3'b000);
      issue(2'd0, 4'h2, 4'h1, 64'h1234, 64'h0, 64'h0, 4'h3, 4'hF, 1'b0, 1'b0);
      check("cmovfail_dstE", bus.out_dstE, 4'hF);
      check("cmovfail_cnd", bus.out_cnd, 1'b0);

      // backpressure: stalled add 3 + (-3)
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_icode = 4'h6; bus.in_ifun = 4'h0;
      bus.in_valA = 64'h3; bus.in_valB = 64'hFFFF_FFFF_FFFF_FFFD; bus.in_dstE = 4'h4;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         check("bp_in_ready", bus.in_ready, 1'b0);
         check("bp_dstE_hold", bus.out_dstE, 4'hF);
         check("bp_cc_hold", bus.cc, 3'b000);
      end
      @(negedge clk) bus.out_ready = 1'b1;
      @(posedge clk); #2;
      check("bp_rel_valE", bus.out_valE, 64'h0);
      check("bp_rel_cc", bus.cc, 3'b100);
      issue(2'd0, 4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h5, 4'hF, 1'b0, 1'b0);
      check("b2b0_valE", bus.out_valE, 64'h2);
      issue(2'd0, 4'h6, 4'h0, 64'h2, 64'h2, 64'h0, 4'h6, 4'hF, 1'b0, 1'b0);
      check("b2b1_valE", bus.out_valE, 64'h4);
      check("b2b1_valid", bus.out_valid, 1'b1);

      // CC protection: INS, flush, cc_block
      issue(2'd3, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h1, 4'hF, 1'b0, 1'b0);
      check("ins_cc", bus.cc, 3'b000);
      check("ins_stat", bus.out_stat, 2'd3);
      issue(2'd0, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h1, 4'hF, 1'b1, 1'b0);
      check("flush_valid", bus.out_valid, 1'b0);
      check("flush_cc", bus.cc, 3'b000);
      issue(2'd0, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h1, 4'hF, 1'b0, 1'b1);
      check("ccb_cc", bus.cc, 3'b000);
      check("ccb_valid", bus.out_valid, 1'b1);

      // mixed icode table
      for (int i = 0; i < 9; i++) begin
         issue(2'd0, vecs[i].ic, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c, 4'h7, 4'h8, 1'b0, 1'b0);
         check($sformatf("vec%0d_valE", i), bus.out_valE, vecs[i].ev);
         check($sformatf("vec%0d_cc", i), bus.cc, vecs[i].ecc);
      end
      // condition table with cc = {ZF=1,SF=0,OF=1}
      for (int i = 0; i < 8; i++) begin
         issue(2'd0, 4'h7, 4'(jf[i]), 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
         check($sformatf("jxx%0d_cnd", jf[i]), bus.out_cnd, je[i]);
      end

      // async reset during a stall
      issue(2'd0, 4'h6, 4'h0, 64'h1, 64'h2, 64'h0, 4'h5, 4'h6, 1'b0, 1'b0);
      @(negedge clk);
      bus.out_ready = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", bus.out_valid, 1'b0);
      check("arst_cc", bus.cc, 3'b100);
      check("arst_dstE", bus.out_dstE, 4'hF);
      check("arst_dstM", bus.out_dstM, 4'hF);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      issue(2'd0, 4'h6, 4'h1, 64'hA, 64'h13, 64'h0, 4'h2, 4'hF, 1'b0, 1'b0);
      check("post_rst_valE", bus.out_valE, 64'h9);
      idle();
      repeat (3) @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
